// File: rtl/ch_unit_pkg.sv
// rtl/ch_unit_pkg.sv - shared types and constants for the channel unit
package ch_unit_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        PB_IDLE,
        PB_ARMED,
        PB_DELAY,
        PB_PLAY,
        PB_RELOAD,
        PB_DONE
    } pb_state_t;

    function automatic logic pb_is_busy(input pb_state_t s);
        return (s == PB_DELAY) || (s == PB_PLAY) || (s == PB_RELOAD);
    endfunction

endpackage

// File: rtl/playback_seq_if.sv
// rtl/playback_seq_if.sv - sequencer to channel RAM controller control signals
interface playback_seq_if;
    logic playback_en;
    logic reload_addr;
    logic playback_done;

    modport master (
        output playback_en,
        output reload_addr,
        input  playback_done
    );

    modport slave (
        input  playback_en,
        input  reload_addr,
        output playback_done
    );
endinterface

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop synchroniser with rising-edge detector
module sync_edge
    import ch_unit_pkg::*;
(
    input  logic clk_i,
    input  logic resetn_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/playback_seq.sv
// rtl/playback_seq.sv - arm/trigger driven, delayed and repeated playback sequencer
module playback_seq
    import ch_unit_pkg::*;
#(
    parameter int DELAY_BITS  = 32,
    parameter int REPEAT_BITS = 16,
    parameter int RELOAD_LEN  = 4
)
(
    input  logic                   playback_clk,
    input  logic                   s_axi_reset,
    input  logic                   arm,
    input  logic                   trigger_in,
    input  logic                   abort,
    input  logic [DELAY_BITS-1:0]  start_delay,
    input  logic [REPEAT_BITS-1:0] repeat_count,
    playback_seq_if.master         ram,
    output logic                   armed,
    output logic                   busy,
    output logic                   done,
    output logic [REPEAT_BITS-1:0] iter_count
);

    localparam int              RL_W    = $clog2(RELOAD_LEN + 1);
    localparam logic [RL_W-1:0] RL_LOAD = RL_W'(RELOAD_LEN);

    logic arm_level, arm_rise;
    logic trig_level, trig_rise;

    sync_edge u_arm_sync (
        .clk_i    (playback_clk),
        .resetn_i (s_axi_reset),
        .async_i  (arm),
        .level_o  (arm_level),
        .rise_o   (arm_rise)
    );

    sync_edge u_trig_sync (
        .clk_i    (playback_clk),
        .resetn_i (s_axi_reset),
        .async_i  (trigger_in),
        .level_o  (trig_level),
        .rise_o   (trig_rise)
    );

    pb_state_t              state_q, state_d;
    pb_state_t              ret_q, ret_d;
    logic [DELAY_BITS-1:0]  delay_lat_q, delay_lat_d;
    logic [DELAY_BITS-1:0]  delay_cnt_q, delay_cnt_d;
    logic [REPEAT_BITS-1:0] rep_lat_q, rep_lat_d;
    logic [REPEAT_BITS-1:0] iter_q, iter_d;
    logic [REPEAT_BITS-1:0] iter_inc;
    logic [RL_W-1:0]        reload_cnt_q, reload_cnt_d;
    logic                   first_q, first_d;
    logic                   en_q, reload_q, armed_q, busy_q, done_q;

    assign iter_inc = iter_q + REPEAT_BITS'(1);

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        delay_lat_d  = delay_lat_q;
        delay_cnt_d  = delay_cnt_q;
        rep_lat_d    = rep_lat_q;
        iter_d       = iter_q;
        reload_cnt_d = reload_cnt_q;
        first_d      = 1'b0;

        if (abort) begin
            state_d = PB_IDLE;
        end else begin
            case (state_q)
                PB_IDLE: begin
                    if (arm_rise) begin
                        delay_lat_d  = start_delay;
                        rep_lat_d    = repeat_count;
                        iter_d       = '0;
                        ret_d        = PB_ARMED;
                        reload_cnt_d = RL_LOAD;
                        state_d      = PB_RELOAD;
                    end
                end
                PB_ARMED: begin
                    if (trig_rise) begin
                        if (delay_lat_q != '0) begin
                            delay_cnt_d = delay_lat_q;
                            state_d     = PB_DELAY;
                        end else begin
                            first_d = 1'b1;
                            state_d = PB_PLAY;
                        end
                    end
                end
                PB_DELAY: begin
                    if (delay_cnt_q == DELAY_BITS'(1)) begin
                        first_d = 1'b1;
                        state_d = PB_PLAY;
                    end else begin
                        delay_cnt_d = delay_cnt_q - DELAY_BITS'(1);
                    end
                end
                PB_PLAY: begin
                    // The controller's done flag is stale on the first enabled cycle.
                    if (!first_q && ram.playback_done) begin
                        iter_d = iter_inc;
                        if ((rep_lat_q == '0) || (iter_inc < rep_lat_q)) begin
                            ret_d        = PB_PLAY;
                            reload_cnt_d = RL_LOAD;
                            state_d      = PB_RELOAD;
                        end else begin
                            state_d = PB_DONE;
                        end
                    end
                end
                PB_RELOAD: begin
                    if (reload_cnt_q == RL_W'(1)) begin
                        first_d = (ret_q == PB_PLAY);
                        state_d = ret_q;
                    end else begin
                        reload_cnt_d = reload_cnt_q - RL_W'(1);
                    end
                end
                PB_DONE: begin
                    if (!arm_level) begin
                        state_d = PB_IDLE;
                    end
                end
                default: state_d = PB_IDLE;
            endcase
        end
    end

    always_ff @(posedge playback_clk or negedge s_axi_reset) begin
        if (!s_axi_reset) begin
            state_q      <= PB_IDLE;
            ret_q        <= PB_ARMED;
            delay_lat_q  <= '0;
            delay_cnt_q  <= '0;
            rep_lat_q    <= '0;
            iter_q       <= '0;
            reload_cnt_q <= '0;
            first_q      <= 1'b0;
            en_q         <= 1'b0;
            reload_q     <= 1'b0;
            armed_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            delay_lat_q  <= delay_lat_d;
            delay_cnt_q  <= delay_cnt_d;
            rep_lat_q    <= rep_lat_d;
            iter_q       <= iter_d;
            reload_cnt_q <= reload_cnt_d;
            first_q      <= first_d;
            // Outputs are decoded from the next state so they change on the same edge.
            en_q         <= (state_d == PB_PLAY);
            reload_q     <= (state_d == PB_RELOAD);
            armed_q      <= (state_d == PB_ARMED);
            busy_q       <= pb_is_busy(state_d);
            done_q       <= (state_d == PB_DONE);
        end
    end

    assign ram.playback_en = en_q;
    assign ram.reload_addr = reload_q;
    assign armed           = armed_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign iter_count      = iter_q;

endmodule

// File: tb/tb_playback_seq.sv
// tb/tb_playback_seq.sv - self-checking bench for playback_seq
module tb_playback_seq;

    localparam int DB = 32;
    localparam int RB = 16;
    localparam int RL = 4;

    logic          playback_clk = 1'b0;
    logic          s_axi_reset  = 1'b0;
    logic          arm          = 1'b0;
    logic          trigger_in   = 1'b0;
    logic          abort        = 1'b0;
    logic [DB-1:0] start_delay  = '0;
    logic [RB-1:0] repeat_count = '0;
    logic          armed, busy, done;
    logic [RB-1:0] iter_count;

    playback_seq_if ram();

    playback_seq #(.DELAY_BITS(DB), .REPEAT_BITS(RB), .RELOAD_LEN(RL)) dut (
        .playback_clk (playback_clk),
        .s_axi_reset  (s_axi_reset),
        .arm          (arm),
        .trigger_in   (trigger_in),
        .abort        (abort),
        .start_delay  (start_delay),
        .repeat_count (repeat_count),
        .ram          (ram),
        .armed        (armed),
        .busy         (busy),
        .done         (done),
        .iter_count   (iter_count)
    );

    always #5 playback_clk = ~playback_clk;

    // RAM controller model: raises done on the 10th enabled edge, drops it once disabled.
    int en_cnt    = 0;
    bit ram_stall = 1'b0;
    always @(posedge playback_clk) begin
        if (!ram.playback_en) begin
            en_cnt            <= 0;
            ram.playback_done <= 1'b0;
        end else begin
            en_cnt <= en_cnt + 1;
            if (en_cnt == 9 && !ram_stall) ram.playback_done <= 1'b1;
        end
    end

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    logic          prev_en = 1'b0, prev_rl = 1'b0;
    int            rl_len = 0;
    bit            rl_skip = 1'b0;
    int            en_rises = 0;
    bit            done_seen = 1'b0;
    logic [RB-1:0] sb[$];

    task automatic mon();
        if (abort) rl_skip = 1'b1;
        if (ram.reload_addr) begin
            if (!prev_rl) begin
                rl_len  = 0;
                rl_skip = abort;
            end
            rl_len++;
        end else if (prev_rl && !rl_skip) begin
            chk("reload_len", rl_len, RL);
        end
        if (ram.playback_en && !prev_en) en_rises++;
        if (!ram.playback_en && prev_en && sb.size() > 0)
            chk("iter_at_pass_end", iter_count, sb.pop_front());
        if (done) done_seen = 1'b1;
        prev_en = ram.playback_en;
        prev_rl = ram.reload_addr;
    endtask

    task automatic tick();
        @(posedge playback_clk);
        #1;
        mon();
    endtask

    task automatic do_arm(input int dly, input int rep);
        int n;
        start_delay  = DB'(dly);
        repeat_count = RB'(rep);
        arm = 1'b1;
        n = 0;
        while (!ram.reload_addr && n < 10) begin tick(); n++; end
        chk("arm_to_reload", n, 3);
        n = 0;
        while (!armed && n < 20) begin tick(); n++; end
        chk("armed_after_reload", armed, 1);
    endtask

    task automatic trig_wait_en(output int n);
        trigger_in = 1'b1;
        n = 0;
        while (!ram.playback_en && n < 400) begin tick(); n++; end
        trigger_in = 1'b0;
    endtask

    task automatic disarm();
        abort = 1'b0;
        arm   = 1'b0;
        repeat (5) tick();
    endtask

    typedef struct {
        int dly;
        int rep;
        int lat;
        int iter;
    } vec_t;
    vec_t vt[4];

    initial begin
        int n;
        vt[0] = '{0,   1, 3,   1};
        vt[1] = '{1,   1, 4,   1};
        vt[2] = '{100, 1, 103, 1};
        vt[3] = '{7,   3, 10,  3};

        repeat (3) @(posedge playback_clk);
        #1;
        chk("rst_en", ram.playback_en, 0);
        chk("rst_reload", ram.reload_addr, 0);
        chk("rst_flags", {armed, busy, done}, 0);
        chk("rst_iter", iter_count, 0);
        s_axi_reset = 1'b1;
        repeat (3) tick();

        // Trigger while idle must do nothing.
        trigger_in = 1'b1;
        repeat (3) tick();
        trigger_in = 1'b0;
        repeat (4) tick();
        chk("idle_trig_ignored", {armed, busy, done, ram.playback_en}, 0);

        for (int i = 0; i < 4; i++) begin
            do_arm(vt[i].dly, vt[i].rep);
            for (int k = 1; k <= vt[i].rep; k++) sb.push_back(RB'(k));
            en_rises = 0;
            trig_wait_en(n);
            chk("trig_to_en", n, vt[i].lat);
            n = 0;
            while (!done && n < 3000) begin tick(); n++; end
            chk("done_reached", done, 1);
            chk("iter_final", iter_count, vt[i].iter);
            chk("play_windows", en_rises, vt[i].rep);
            chk("sb_drained", sb.size(), 0);
            chk("en_off_in_done", ram.playback_en, 0);
            disarm();
            chk("idle_after_disarm", {armed, busy, done}, 0);
        end

        // Triggers during PLAY and DONE, arm held through DONE.
        do_arm(0, 1);
        sb.push_back(RB'(1));
        trig_wait_en(n);
        repeat (2) tick();
        trigger_in = 1'b1;
        repeat (4) tick();
        chk("play_trig_ignored", {ram.playback_en, busy}, 2'b11);
        trigger_in = 1'b0;
        n = 0;
        while (!done && n < 200) begin tick(); n++; end
        chk("done_after_play", done, 1);
        trigger_in = 1'b1;
        repeat (5) tick();
        trigger_in = 1'b0;
        repeat (10) tick();
        chk("done_holds", {done, ram.reload_addr, busy}, 3'b100);
        chk("done_iter", iter_count, 1);
        arm = 1'b0;
        repeat (4) tick();
        chk("done_to_idle", {armed, busy, done}, 0);
        do_arm(0, 1);
        disarm();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (2) tick();

        // Abort during DELAY.
        do_arm(50, 2);
        trigger_in = 1'b1;
        repeat (10) tick();
        trigger_in = 1'b0;
        chk("in_delay", {busy, ram.playback_en}, 2'b10);
        abort = 1'b1;
        tick();
        chk("abort_delay_flags", {armed, busy, done, ram.playback_en, ram.reload_addr}, 0);
        chk("abort_delay_iter", iter_count, 0);
        disarm();

        // Abort during the inter-pass RELOAD.
        do_arm(0, 3);
        sb.push_back(RB'(1));
        trig_wait_en(n);
        n = 0;
        while (!ram.reload_addr && n < 100) begin tick(); n++; end
        chk("reload_between_passes", ram.reload_addr, 1);
        tick();
        abort = 1'b1;
        tick();
        chk("abort_reload_flags", {busy, ram.playback_en, ram.reload_addr}, 0);
        chk("abort_reload_iter", iter_count, 1);
        abort = 1'b0;
        repeat (6) tick();
        chk("abort_stays_idle", {busy, ram.playback_en, ram.reload_addr}, 0);
        sb.delete();
        disarm();

        // Infinite mode: five passes, never done.
        do_arm(0, 0);
        for (int k = 1; k <= 5; k++) sb.push_back(RB'(k));
        done_seen = 1'b0;
        trig_wait_en(n);
        n = 0;
        while (iter_count != 5 && n < 1000) begin tick(); n++; end
        chk("inf_iter", iter_count, 5);
        chk("inf_no_done", done_seen, 0);
        chk("inf_sb_drained", sb.size(), 0);
        abort = 1'b1;
        tick();
        chk("inf_abort_iter", iter_count, 5);
        chk("inf_abort_busy", busy, 0);
        disarm();

        // Asynchronous reset in the middle of the second pass.
        do_arm(0, 2);
        sb.push_back(RB'(1));
        trig_wait_en(n);
        n = 0;
        while (!(iter_count == 1 && ram.playback_en) && n < 200) begin tick(); n++; end
        chk("second_pass_play", {ram.playback_en, iter_count}, {1'b1, RB'(1)});
        #2 s_axi_reset = 1'b0;
        #1;
        chk("async_rst_en", ram.playback_en, 0);
        chk("async_rst_iter", iter_count, 0);
        chk("async_rst_flags", {busy, ram.reload_addr}, 0);
        arm = 1'b0;
        trigger_in = 1'b0;
        tick();
        tick();
        s_axi_reset = 1'b1;
        repeat (5) tick();
        chk("idle_after_rst", {armed, busy, done, ram.playback_en, ram.reload_addr}, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
